hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS-32 pipeline.
- Gates PC and pipeline-register writes, inserts bubbles into the decoded control bundle (WB/MEM/EX fields), and flushes wrong-path instructions.
- Inputs: load-use hazards, taken branches/jumps, and data-memory wait handshakes.
- Sits beside Control; its bubble output drives the mux that zeroes Control's WB/MEM/EX outputs before the ID/EX register.

---
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard/sequencing signal bundle between the 5-stage datapath and hazard_ctrl.
// Data-memory handshake: an access is pending while dmem_req=1 and completes on the cycle dmem_ready=1;
// any cycle with dmem_req=1 and dmem_ready=0 freezes the pipeline until completion.
interface hazard_ctrl_if #(parameter int REG_W = 5);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             ex_branch_taken;
  logic             dmem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_hold;
  logic             memwb_bubble;
  logic             mem_err;
  logic [1:0]       state_dbg;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
           ex_branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
           memwb_bubble, mem_err, state_dbg
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
           ex_branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold,
           memwb_bubble, mem_err, state_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// MIPS-32 5-stage pipeline sequencing: load-use stalls, branch/jump flushes, data-memory wait and timeout.
// Optional performance counters (stall_cycles, flush_count) enabled by defining HAZARD_CTRL_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 16
`ifdef HAZARD_CTRL_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_ctrl_if.slave     hz
`ifdef HAZARD_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       lu;
  logic       mw;

  assign hz.state_dbg = state;

  always_comb begin
    lu = hz.ex_mem_read && (hz.ex_rt != '0) &&
         ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));
    mw = hz.dmem_req && !hz.dmem_ready;
  end

  always_comb begin
    hz.pc_write     = 1'b1;
    hz.ifid_write   = 1'b1;
    hz.ifid_flush   = 1'b0;
    hz.idex_bubble  = 1'b0;
    hz.pipe_hold    = 1'b0;
    hz.memwb_bubble = 1'b0;
    hz.mem_err      = 1'b0;
    if (!rst_n) begin
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.ifid_flush   = 1'b1;
      hz.idex_bubble  = 1'b1;
      hz.memwb_bubble = 1'b1;
    end else if (state == ERR || mw) begin
      // ERR keeps the frozen-pipe pattern forever, plus the sticky error flag
      hz.pc_write     = 1'b0;
      hz.ifid_write   = 1'b0;
      hz.pipe_hold    = 1'b1;
      hz.memwb_bubble = 1'b1;
      hz.mem_err      = (state == ERR);
    end else if (hz.ex_branch_taken) begin
      hz.ifid_flush  = 1'b1;
      hz.idex_bubble = 1'b1;
    end else if (lu) begin
      hz.pc_write    = 1'b0;
      hz.ifid_write  = 1'b0;
      hz.idex_bubble = 1'b1;
    end else if (hz.id_jump) begin
      hz.ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (!mw) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= ERR;
      endcase
    end
  end

`ifdef HAZARD_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!hz.pc_write && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (hz.ifid_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4 build).
module tb_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int W     = 9;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, memwb_bubble, mem_err}
  localparam logic [6:0] O_RST  = 7'b0011010;
  localparam logic [6:0] O_NORM = 7'b1100000;
  localparam logic [6:0] O_HOLD = 7'b0000110;
  localparam logic [6:0] O_BR   = 7'b1111000;
  localparam logic [6:0] O_LU   = 7'b0001000;
  localparam logic [6:0] O_JMP  = 7'b1110000;
  localparam logic [6:0] O_ERR  = 7'b0000111;
  localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_ERR = 2'd2;

  logic clk;
  logic rst_n;
  hazard_ctrl_if #(.REG_W(REG_W)) hz ();

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];
  int stall_exp;
  int flush_exp;

`ifdef HAZARD_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz.slave),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
`else
  hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .hz(hz.slave)
  );
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one call = one clock cycle of stimulus plus its expected response
  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic jump, input logic mem_read,
                       input logic [4:0] ert, input logic br, input logic req,
                       input logic rdy, input logic [6:0] exp_o, input logic [1:0] exp_s);
    @(posedge clk);
    #1;
    rst_n                 = rst;
    hz.id_rs              = rs;
    hz.id_rt              = rt;
    hz.id_uses_rt         = uses_rt;
    hz.id_jump            = jump;
    hz.ex_mem_read        = mem_read;
    hz.ex_rt              = ert;
    hz.ex_branch_taken    = br;
    hz.dmem_req           = req;
    hz.dmem_ready         = rdy;
    exp_q.push_back({exp_o, exp_s});
    if (rst && !exp_o[6]) stall_exp++;
    if (rst && exp_o[4])  flush_exp++;
  endtask

  task automatic idle(input logic [6:0] exp_o, input logic [1:0] exp_s);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp_o, exp_s);
  endtask

  task automatic mem(input logic req, input logic rdy, input logic [6:0] exp_o,
                     input logic [1:0] exp_s);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, req, rdy, exp_o, exp_s);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble, hz.pipe_hold,
           hz.memwb_bubble, hz.mem_err, hz.state_dbg};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs@%0t got=%b want=%b (pc,ifw,fl,bb,hold,mwb,err,state)",
                 $time, a, e);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; stall_exp = 0; flush_exp = 0;
    rst_n = 1'b0;
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0; hz.id_jump = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rt = '0; hz.ex_branch_taken = 1'b0;
    hz.dmem_req = 1'b0; hz.dmem_ready = 1'b0;

    // reset then release
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, S_RUN);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, S_RUN);
    idle(O_NORM, S_RUN);

    // load-use on rs, one-cycle stall; register 0 never stalls
    drive(1'b1, 5'd8, 5'd1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, O_LU, S_RUN);
    drive(1'b1, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, O_NORM, S_RUN);
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, O_NORM, S_RUN);

    // load-use on rt, gated by id_uses_rt
    drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_LU, S_RUN);
    drive(1'b1, 5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, O_NORM, S_RUN);

    // branch beats load-use and jump; jump alone flushes without bubble
    drive(1'b1, 5'd8, 5'd1, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, O_BR, S_RUN);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_JMP, S_RUN);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, O_BR, S_RUN);
    // load-use beats jump
    drive(1'b1, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, O_LU, S_RUN);

    // memory wait 3 cycles, release on ready
    mem(1'b1, 1'b0, O_HOLD, S_RUN);
    mem(1'b1, 1'b0, O_HOLD, S_MW);
    mem(1'b1, 1'b0, O_HOLD, S_MW);
    mem(1'b1, 1'b1, O_NORM, S_MW);
    idle(O_NORM, S_RUN);

    // hazards ignored while held; req dropping counts as completion and re-evaluates jump
    mem(1'b1, 1'b0, O_HOLD, S_RUN);
    drive(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, O_HOLD, S_MW);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_JMP, S_MW);
    idle(O_NORM, S_RUN);

    // reset mid-wait returns to RUN
    mem(1'b1, 1'b0, O_HOLD, S_RUN);
    mem(1'b1, 1'b0, O_HOLD, S_MW);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, O_RST, S_MW);
    idle(O_NORM, S_RUN);

    // timeout with MEM_TIMEOUT=4: wait_cnt 1..4 in MEM_WAIT, then ERR
    mem(1'b1, 1'b0, O_HOLD, S_RUN);
    mem(1'b1, 1'b0, O_HOLD, S_MW);
    mem(1'b1, 1'b0, O_HOLD, S_MW);
    mem(1'b1, 1'b0, O_HOLD, S_MW);
    mem(1'b1, 1'b0, O_HOLD, S_MW);
    mem(1'b1, 1'b0, O_ERR, S_ERR);
    mem(1'b1, 1'b1, O_ERR, S_ERR);
    idle(O_ERR, S_ERR);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_RST, S_ERR);
    idle(O_NORM, S_RUN);
    // counters restart from zero after that reset
    stall_exp = 0;
    flush_exp = 0;
    drive(1'b1, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, O_LU, S_RUN);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_JMP, S_RUN);
    mem(1'b1, 1'b0, O_HOLD, S_RUN);
    mem(1'b1, 1'b1, O_NORM, S_MW);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d want=0 pending", exp_q.size());
    end

`ifdef HAZARD_CTRL_PERF_CNT_EN
    @(posedge clk);
    #1;
    checks++;
    if (stall_cycles !== 32'(stall_exp)) begin
      errors++;
      $display("FAIL stall_cycles got=%0d want=%0d", stall_cycles, stall_exp);
    end
    checks++;
    if (flush_count !== 32'(flush_exp)) begin
      errors++;
      $display("FAIL flush_count got=%0d want=%0d", flush_count, flush_exp);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
